// File: rtl/mdu_divresult.sv
// mdu_divresult: radix-2 restoring divider (E) + result select/W64 fixup (M) + W reg.
// Optional MDU_DIV_FASTSPECIAL_EN: div-by-zero/overflow skip straight to DONE.
module mdu_divresult #(
  parameter int XLEN = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              StallM,
  input  logic              FlushE,
  input  logic              FlushM,
  input  logic              StallW,
  input  logic              FlushW,
  input  logic [XLEN-1:0]   ForwardedSrcAE,
  input  logic [XLEN-1:0]   ForwardedSrcBE,
  input  logic [2:0]        Funct3E,
  input  logic              W64E,
  input  logic              IntDivE,
  input  logic [2*XLEN-1:0] ProdM,
  input  logic [2:0]        Funct3M,
  input  logic              W64M,
  output logic              DivBusyE,
  output logic [XLEN-1:0]   MDUResultW
);

  localparam int CW = $clog2(XLEN);
  localparam int SH = XLEN - 32;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state, state_n;

  logic            w_e, sgn_op, sa, sb;
  logic            div0, ovf, div_start, fast_hit;
  logic [XLEN-1:0] a_ext, b_ext, abs_a, abs_b, min_v;
  logic [XLEN-1:0] spec_q, spec_rem;

  logic [XLEN-1:0] rem_r, quo_r, dvs_r;
  logic [CW-1:0]   cnt;
  logic            sa_r, sq_r, spec_r;
  logic [XLEN-1:0] spec_q_r, spec_rem_r;
  logic [XLEN-1:0] quot_res, rem_res;

  logic [XLEN:0]   rs, diff;
  logic            ge;
  logic [XLEN-1:0] nrem, nquo;

  logic [XLEN-1:0] QuotM, RemM;
  logic [XLEN-1:0] sel_m, res_m;

  logic unused;

  // Bits [31:0] of v, sign- or zero-extended to XLEN.
  function automatic logic [XLEN-1:0] ext32(
    input logic [XLEN-1:0] v,
    input logic            s
  );
    logic [XLEN-1:0] t;
    t = v << SH;
    if (s) ext32 = $signed(t) >>> SH;
    else   ext32 = t >> SH;
  endfunction

  assign w_e    = (XLEN == 64) ? W64E : 1'b0;
  assign sgn_op = ~Funct3E[0];

  // Operand conditioning: word extension, signs, magnitudes, special cases.
  always_comb begin
    a_ext    = w_e ? ext32(ForwardedSrcAE, sgn_op) : ForwardedSrcAE;
    b_ext    = w_e ? ext32(ForwardedSrcBE, sgn_op) : ForwardedSrcBE;
    sa       = sgn_op & a_ext[XLEN-1];
    sb       = sgn_op & b_ext[XLEN-1];
    abs_a    = sa ? -a_ext : a_ext;
    abs_b    = sb ? -b_ext : b_ext;
    min_v    = w_e ? ext32(XLEN'(1) << 31, 1'b1)
                   : XLEN'(1) << (XLEN - 1);
    div0     = (b_ext == '0);
    ovf      = sgn_op & (a_ext == min_v) & (&b_ext);
    spec_q   = div0 ? '1 : a_ext;
    spec_rem = div0 ? a_ext : '0;
  end

  assign div_start = IntDivE & ~FlushE & (state == IDLE);

`ifdef MDU_DIV_FASTSPECIAL_EN
  assign fast_hit = div0 | ovf;
`else
  assign fast_hit = 1'b0;
`endif

  // One restoring step: shift, trial subtract, quotient bit.
  always_comb begin
    rs   = {rem_r, quo_r[XLEN-1]};
    diff = rs - {1'b0, dvs_r};
    ge   = (rs >= {1'b0, dvs_r});
    nrem = ge ? diff[XLEN-1:0] : rs[XLEN-1:0];
    nquo = {quo_r[XLEN-2:0], ge};
  end

  // Divider state register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Divider next-state.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (div_start) state_n = fast_hit ? DONE : BUSY;
      BUSY: begin
        if (FlushE)          state_n = IDLE;
        else if (cnt == '0)  state_n = DONE;
      end
      DONE: if (FlushE | ~StallM) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Stall request: start cycle plus every live BUSY cycle.
  always_comb begin
    DivBusyE = div_start | ((state == BUSY) & ~FlushE);
  end

  // Divider datapath: operand latch, iteration, sign fix-up.
  always_ff @(posedge clk) begin
    if (reset) begin
      rem_r      <= '0;
      quo_r      <= '0;
      dvs_r      <= '0;
      cnt        <= '0;
      sa_r       <= 1'b0;
      sq_r       <= 1'b0;
      spec_r     <= 1'b0;
      spec_q_r   <= '0;
      spec_rem_r <= '0;
      quot_res   <= '0;
      rem_res    <= '0;
    end else begin
      unique case (state)
        IDLE: if (div_start) begin
          rem_r      <= '0;
          quo_r      <= w_e ? abs_a << SH : abs_a;
          dvs_r      <= abs_b;
          cnt        <= w_e ? CW'(31) : CW'(XLEN - 1);
          sa_r       <= sa;
          sq_r       <= sa ^ sb;
          spec_r     <= div0 | ovf;
          spec_q_r   <= spec_q;
          spec_rem_r <= spec_rem;
          if (fast_hit) begin
            quot_res <= spec_q;
            rem_res  <= spec_rem;
          end
        end
        BUSY: begin
          rem_r <= nrem;
          quo_r <= nquo;
          cnt   <= cnt - 1'b1;
          if (cnt == '0) begin
            quot_res <= spec_r ? spec_q_r
                      : (sq_r ? -nquo : nquo);
            rem_res  <= spec_r ? spec_rem_r
                      : (sa_r ? -nrem : nrem);
          end
        end
        default: ;
      endcase
    end
  end

  // E->M pipeline register for divide results.
  always_ff @(posedge clk) begin
    if (reset | FlushM) begin
      QuotM <= '0;
      RemM  <= '0;
    end else if (~StallM) begin
      QuotM <= quot_res;
      RemM  <= rem_res;
    end
  end

  // M-stage result select and word fix-up.
  always_comb begin
    sel_m = ProdM[XLEN-1:0];
    unique case (1'b1)
      (Funct3M == 3'b000):
        sel_m = ProdM[XLEN-1:0];
      (~Funct3M[2] & |Funct3M[1:0]):
        sel_m = ProdM[2*XLEN-1:XLEN];
      (Funct3M[2:1] == 2'b10):
        sel_m = QuotM;
      (Funct3M[2:1] == 2'b11):
        sel_m = RemM;
      default:
        sel_m = ProdM[XLEN-1:0];
    endcase
    res_m = (W64M && XLEN == 64) ? ext32(sel_m, 1'b1) : sel_m;
  end

  // Writeback register; flush beats capture.
  always_ff @(posedge clk) begin
    if (reset | FlushW) MDUResultW <= '0;
    else if (~StallW)   MDUResultW <= res_m;
  end

  assign unused = ^{Funct3E[2:1], diff[XLEN]};

endmodule

// File: tb/tb_mdu_divresult.sv
// tb_mdu_divresult: directed vectors for divider timing, specials, result path.
// Expected busy counts follow MDU_DIV_FASTSPECIAL_EN when defined.
module tb_mdu_divresult;

  logic         clk = 1'b0;
  logic         reset;
  logic         StallM, FlushE, FlushM, StallW, FlushW;
  logic [63:0]  ForwardedSrcAE, ForwardedSrcBE;
  logic [2:0]   Funct3E, Funct3M;
  logic         W64E, IntDivE, W64M;
  logic [127:0] ProdM;
  logic         DivBusyE;
  logic [63:0]  MDUResultW;

  int checks = 0;
  int errors = 0;

`ifdef MDU_DIV_FASTSPECIAL_EN
  localparam int SPN = 1;
`else
  localparam int SPN = 65;
`endif

  mdu_divresult #(.XLEN(64)) dut (
    .clk            (clk),
    .reset          (reset),
    .StallM         (StallM),
    .FlushE         (FlushE),
    .FlushM         (FlushM),
    .StallW         (StallW),
    .FlushW         (FlushW),
    .ForwardedSrcAE (ForwardedSrcAE),
    .ForwardedSrcBE (ForwardedSrcBE),
    .Funct3E        (Funct3E),
    .W64E           (W64E),
    .IntDivE        (IntDivE),
    .ProdM          (ProdM),
    .Funct3M        (Funct3M),
    .W64M           (W64M),
    .DivBusyE       (DivBusyE),
    .MDUResultW     (MDUResultW)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run_div(
    input string       tag,
    input logic [63:0] a,
    input logic [63:0] b,
    input logic [2:0]  f3,
    input logic        w,
    input int          exp_n,
    input logic [63:0] exp_r
  );
    int n;
    @(posedge clk); #1;
    FlushE         = 1'b0;
    ForwardedSrcAE = a;
    ForwardedSrcBE = b;
    Funct3E        = f3;
    W64E           = w;
    IntDivE        = 1'b1;
    Funct3M        = f3;
    W64M           = w;
    n = 0;
    @(negedge clk);
    while (DivBusyE && n < 200) begin
      n++;
      @(posedge clk); #1;
      IntDivE = 1'b0;
      @(negedge clk);
    end
    IntDivE = 1'b0;
    chk({tag, "_busy"}, 64'(n), 64'(exp_n));
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_res"}, MDUResultW, exp_r);
  endtask

  task automatic mul_step(
    input string       tag,
    input logic [2:0]  f3,
    input logic        w,
    input logic        stw,
    input logic        flw,
    input logic [63:0] exp_r
  );
    @(posedge clk); #1;
    Funct3M = f3;
    W64M    = w;
    StallW  = stw;
    FlushW  = flw;
    @(posedge clk); #1;
    StallW  = 1'b0;
    FlushW  = 1'b0;
    @(negedge clk);
    chk(tag, MDUResultW, exp_r);
  endtask

  initial begin
    reset          = 1'b1;
    StallM         = 1'b0;
    FlushE         = 1'b0;
    FlushM         = 1'b0;
    StallW         = 1'b0;
    FlushW         = 1'b0;
    ForwardedSrcAE = '0;
    ForwardedSrcBE = '0;
    Funct3E        = 3'b000;
    Funct3M        = 3'b000;
    W64E           = 1'b0;
    W64M           = 1'b0;
    IntDivE        = 1'b0;
    ProdM          = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(DivBusyE), 64'd0);
    chk("rst_res", MDUResultW, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    run_div("div_m7_2", -64'sd7, 64'd2, 3'b100, 1'b0,
            65, 64'hFFFF_FFFF_FFFF_FFFD);
    run_div("rem_m7_2", -64'sd7, 64'd2, 3'b110, 1'b0,
            65, 64'hFFFF_FFFF_FFFF_FFFF);
    run_div("remuw", 64'hFFFF_FFFF_0000_0011, 64'd5, 3'b111, 1'b1,
            33, 64'd2);
    run_div("divw", 64'h0000_0000_FFFF_FFEC, 64'd3, 3'b100, 1'b1,
            33, 64'hFFFF_FFFF_FFFF_FFFA);
    run_div("divu_100_7", 64'd100, 64'd7, 3'b101, 1'b0,
            65, 64'd14);
    run_div("div_ovf", 64'h8000_0000_0000_0000, '1, 3'b100, 1'b0,
            SPN, 64'h8000_0000_0000_0000);
    run_div("divu_0", 64'h55, 64'd0, 3'b101, 1'b0,
            SPN, 64'hFFFF_FFFF_FFFF_FFFF);
    run_div("rem_0", 64'h1234, 64'd0, 3'b110, 1'b0,
            SPN, 64'h1234);

    @(posedge clk); #1;
    ForwardedSrcAE = 64'd100;
    ForwardedSrcBE = 64'd7;
    Funct3E        = 3'b100;
    W64E           = 1'b0;
    IntDivE        = 1'b1;
    @(posedge clk); #1;
    IntDivE = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    FlushE = 1'b1;
    @(negedge clk);
    chk("flush_drop", 64'(DivBusyE), 64'd0);
    run_div("after_flush", 64'd6, 64'd3, 3'b100, 1'b0,
            65, 64'd2);

    ProdM = {64'h0000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFE};
    mul_step("mulh", 3'b001, 1'b0, 1'b0, 1'b0, 64'd1);
    mul_step("mulw", 3'b000, 1'b1, 1'b0, 1'b0,
             64'hFFFF_FFFF_FFFF_FFFE);
    mul_step("stallw", 3'b001, 1'b0, 1'b1, 1'b0,
             64'hFFFF_FFFF_FFFF_FFFE);
    mul_step("flushw", 3'b001, 1'b0, 1'b0, 1'b1, 64'd0);
    ProdM = {64'h0, 64'h1234_5678_0000_0005};
    mul_step("mul_lo", 3'b000, 1'b0, 1'b0, 1'b0,
             64'h1234_5678_0000_0005);
    mul_step("mulw_pos", 3'b000, 1'b1, 1'b0, 1'b0, 64'd5);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_divresult.md
Name: mdu_divresult

Overview:
- Back half of the integer multiply/divide unit.
- Contains the iterative radix-2 divider that runs in the Execute stage and stalls it while busy.
- Consumes the double-width product from the Memory-stage multiplier, selects product or divide result per Funct3M, applies word (W64) truncation/sign-extension, and registers MDUResultW into Writeback.

Parameters:
- XLEN, 64, integer datapath width (32 or 64).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- StallM  in  1  Memory stage stall; E->M advance when low
- FlushE  in  1  kill Execute-stage instruction
- FlushM  in  1  kill Memory-stage instruction
- StallW  in  1  Writeback stage stall
- FlushW  in  1  kill Writeback-stage instruction
- ForwardedSrcAE  in  XLEN  dividend (after forwarding)
- ForwardedSrcBE  in  XLEN  divisor (after forwarding)
- Funct3E  in  3  operation in E; bit0=1 unsigned divide
- W64E  in  1  word (32-bit) operation in E
- IntDivE  in  1  E instruction is DIV/DIVU/REM/REMU(W)
- ProdM  in  2*XLEN  product from multiplier, M stage
- Funct3M  in  3  operation in M
- W64M  in  1  word operation in M
- DivBusyE  out  1  stall request to hazard unit
- MDUResultW  out  XLEN  final result

Behaviour:
- Clock and reset: one clock `clk`; `reset` is synchronous and active-high.
- Reset value of every output and register: state IDLE; DivBusyE=0; MDUResultW=0; QuotM/RemM=0.
- Divider FSM states: IDLE, BUSY, DONE.
- Start condition: DivStartE = IntDivE & ~FlushE & (state==IDLE).
- Iteration count N: N=32 if W64E or XLEN==32; otherwise N=XLEN.
  - W64 operands use bits [31:0] only; sign is taken from bit 31.
- Start cycle (IDLE, DivStartE):
  - Latch |dividend| and |divisor|; signed when Funct3E[0]==0.
  - Latch sign flags and W64E.
  - Counter := N-1; go to BUSY.
- BUSY: one restoring step per cycle (shift remainder, trial subtract, quotient bit).
  - When counter==0, apply sign fix-up and go to DONE.
  - Quotient sign = sA^sB; remainder sign = sA.
- DONE: results held. Go to IDLE on the first cycle with ~StallM; the instruction advances to M in that cycle.
- DivBusyE = DivStartE | (state==BUSY). This gives N+1 stall cycles; DivBusyE is low in DONE.
- FlushE in BUSY or DONE: return to IDLE next cycle; DivBusyE drops immediately.
- Mid-divide reset: return to IDLE next cycle.
- IntDivE is ignored in BUSY and DONE.
- Special cases (RISC-V spec):
  - Divisor 0: quotient all-ones; remainder = dividend.
  - Signed overflow (MIN / -1): quotient = MIN; remainder = 0.
  - In W64 mode, MIN is 0x8000_0000.
- E->M register: when ~StallM, QuotM/RemM capture the DONE results; FlushM clears them.
- M-stage result select (pre-W64):
  - 000: ProdM[XLEN-1:0]
  - 001/010/011: ProdM[2XLEN-1:XLEN]
  - 100/101: QuotM
  - 110/111: RemM
- W64M (XLEN=64 only): result = sign-extend bits [31:0] to 64.
- W register: captures the selected result on ~StallW; FlushW clears it to 0. FlushW wins over a simultaneous capture.
- Multiply path latency: ProdM valid in M, so MDUResultW updates one edge later.

Optional Feature:
- Macro: MDU_DIV_FASTSPECIAL_EN.
- Defined: divisor==0 or signed overflow detected at start goes IDLE->DONE directly, with results from the special-case rule. DivBusyE is high for exactly 1 cycle.
- Undefined: special cases still run the full N BUSY cycles; final results are identical.

Test Plan:
- XLEN=64, DIV (Funct3E=100), A=-7, B=2 -> DivBusyE high 65 cycles, then QuotM=-3, MDUResultW=0xFFFF_FFFF_FFFF_FFFD.
- REMUW (Funct3E=111, W64E=1), A=0xFFFF_FFFF_0000_0011, B=5:
  - DivBusyE high 33 cycles.
  - MDUResultW = sign-extend(0x11 % 5) = 2.
- DIV A=0x8000_0000_0000_0000, B=-1 -> MDUResultW=0x8000_0000_0000_0000.
- DIVU with B=0 -> quotient 0xFFFF_FFFF_FFFF_FFFF.
- REM A=0x1234, B=0 -> 0x1234.
- Repeat both special-case tests with MDU_DIV_FASTSPECIAL_EN: DivBusyE high exactly 1 cycle.
- Assert FlushE on BUSY cycle 10 -> DivBusyE=0 next cycle, state IDLE; a new DIV 6/3 starts the following cycle and yields 2.
- MULH path: Funct3M=001, ProdM=0x0000_0000_0000_0001_FFFF_FFFF_FFFF_FFFE, StallW=0 -> MDUResultW=0x1 next edge.
- Same ProdM, Funct3M=000, W64M=1 -> MDUResultW=0xFFFF_FFFF_FFFF_FFFE.
- Same ProdM, StallW=1 -> MDUResultW holds.
- FlushW with a simultaneous capture -> MDUResultW=0.
